// File: rtl/cpu_machine_ctrl_if.sv
// Control bundle between the machine-cycle controller (master) and the datapath (slave).
interface cpu_machine_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ena;
    logic [2:0]       opcode;
    logic             zero;
    logic             inc_pc;
    logic             load_pc;
    logic             load_ir;
    logic             load_acc;
    logic             rd;
    logic             wr;
    logic             datactl_ena;
    logic             halt;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  ena, opcode, zero,
        output inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt, state, instr_cnt
    );

    modport slave (
        output ena, opcode, zero,
        input  inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt, state, instr_cnt
    );
endinterface

// File: rtl/cpu_machine_ctrl.sv
// Eight-state machine-cycle controller for the 8-bit RISC core: sequences fetch,
// decode and execute strobes, tracks HLT and counts retired instructions.
module cpu_machine_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    cpu_machine_ctrl_if.master  io_bus
);

    typedef enum logic [2:0] {
        S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
        S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
    } state_t;

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_SKZ  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ANDD = 3'b011;
    localparam logic [2:0] OP_XORR = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_STO  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    function automatic logic is_alu(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
    endfunction

    state_t           r_state;
    logic             r_halted;
    logic             r_skip;
    logic [CNT_W-1:0] r_instr_cnt;

    logic w_run;
    logic w_alu;
    logic w_sto;
    logic w_jmp;
    logic w_skz;
    logic w_inc_pc;
    logic w_load_pc;
    logic w_load_ir;
    logic w_load_acc;
    logic w_rd;
    logic w_wr;
    logic w_datactl_ena;
    logic w_halt;

    // Strobes are live only while out of reset, enabled and not halted.
    assign w_run = rst & io_bus.ena & ~r_halted;
    assign w_alu = is_alu(io_bus.opcode);
    assign w_sto = (io_bus.opcode == OP_STO);
    assign w_jmp = (io_bus.opcode == OP_JMP);
    assign w_skz = (io_bus.opcode == OP_SKZ);

    // Per-state strobe decode from the current state and opcode.
    always_comb begin
        w_inc_pc      = 1'b0;
        w_load_pc     = 1'b0;
        w_load_ir     = 1'b0;
        w_load_acc    = 1'b0;
        w_rd          = 1'b0;
        w_wr          = 1'b0;
        w_datactl_ena = 1'b0;
        w_halt        = r_halted;
        if (w_run) begin
            case (r_state)
                S0: begin
                    w_rd      = 1'b1;
                    w_load_ir = 1'b1;
                end
                S1: w_inc_pc = 1'b1;
                S2: begin
                    w_rd      = 1'b1;
                    w_load_ir = 1'b1;
                end
                S3: begin
                    w_inc_pc = 1'b1;
                    w_halt   = (io_bus.opcode == OP_HLT);
                end
                S4: begin
                    w_rd          = w_alu;
                    w_load_pc     = w_jmp;
                    w_datactl_ena = w_sto;
                end
                S5: begin
                    w_rd          = w_alu;
                    w_load_acc    = w_alu;
                    w_datactl_ena = w_sto;
                    w_wr          = w_sto;
                    w_load_pc     = w_jmp;
                    w_inc_pc      = w_skz & io_bus.zero;
                end
                S6: w_datactl_ena = w_sto;
                // S7 uses the skip decision latched in S5, not the live zero flag.
                S7: w_inc_pc = w_skz & r_skip;
                default: w_inc_pc = 1'b0;
            endcase
        end else begin
            w_halt = r_halted;
        end
    end

    // State sequencing, halt latch, skip latch and retired-instruction count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S0;
            r_halted    <= 1'b0;
            r_skip      <= 1'b0;
            r_instr_cnt <= {CNT_W{1'b0}};
        end else if (r_halted) begin
            r_state <= r_state;
        end else if (!io_bus.ena) begin
            r_state <= S0;
            r_skip  <= 1'b0;
        end else begin
            case (r_state)
                S0: r_state <= S1;
                S1: r_state <= S2;
                S2: r_state <= S3;
                S3: begin
                    if (io_bus.opcode == OP_HLT) begin
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S4;
                    end
                end
                S4: r_state <= S5;
                S5: begin
                    r_state <= S6;
                    r_skip  <= w_skz & io_bus.zero;
                end
                S6: r_state <= S7;
                S7: begin
                    r_state     <= S0;
                    r_skip      <= 1'b0;
                    r_instr_cnt <= r_instr_cnt + CNT_W'(1);
                end
                default: r_state <= S0;
            endcase
        end
    end

    assign io_bus.inc_pc      = w_inc_pc;
    assign io_bus.load_pc     = w_load_pc;
    assign io_bus.load_ir     = w_load_ir;
    assign io_bus.load_acc    = w_load_acc;
    assign io_bus.rd          = w_rd;
    assign io_bus.wr          = w_wr;
    assign io_bus.datactl_ena = w_datactl_ena;
    assign io_bus.halt        = w_halt;
    assign io_bus.state       = r_state;
    assign io_bus.instr_cnt   = r_instr_cnt;

endmodule
